// File: rtl/rr_mux_n.sv
// rr_mux_n: N-channel round-robin multiplexer with valid/ready handshakes
// on every input and a registered one-entry output stage.
module rr_mux_n #(
   parameter int unsigned N_CH = 4,
   parameter int unsigned W    = 4,
   parameter int unsigned CW   = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_CH-1:0]   in_valid,
   input  logic [N_CH*W-1:0] in_data,
   output logic [N_CH-1:0]   in_ready,
   output logic              out_valid,
   output logic [W-1:0]      out_data,
   output logic [CW-1:0]     out_ch,
   input  logic              out_ready
);

   logic [CW-1:0] ptr_q, ptr_d;
   logic          out_valid_q, out_valid_d;
   logic [W-1:0]  out_data_q, out_data_d;
   logic [CW-1:0] out_ch_q, out_ch_d;

   logic          can_load;
   logic          found;
   logic          grant;
   logic [CW-1:0] gnt_idx;
   logic [W-1:0]  gnt_data;

   assign can_load = !out_valid_q || out_ready;
   assign grant    = can_load && found && !rst;

   // Rotating scan done as two priority passes: channels at or above ptr
   // first, then the lowest valid channel below ptr (the wrapped part).
   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (!found && in_valid[i] && (CW'(i) >= ptr_q)) begin
            found   = 1'b1;
            gnt_idx = CW'(i);
         end
      end
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (!found && in_valid[i]) begin
            found   = 1'b1;
            gnt_idx = CW'(i);
         end
      end
   end

   always_comb begin
      gnt_data = '0;
      in_ready = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         if (gnt_idx == CW'(i)) begin
            gnt_data    = in_data[i*W +: W];
            in_ready[i] = grant;
         end
      end
   end

   always_comb begin
      ptr_d       = ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      if (grant) begin
         out_valid_d = 1'b1;
         out_data_d  = gnt_data;
         out_ch_d    = gnt_idx;
         ptr_d       = (gnt_idx == CW'(N_CH - 1)) ? '0 : gnt_idx + CW'(1);
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
      end else begin
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_mux_n.sv
// Self-checking bench for rr_mux_n: directed scenarios plus randomized traffic
// compared against a round-robin reference model (4-channel and 3-channel DUTs).
module tb_rr_mux_n;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [3:0]  v4 = '0, r4;
   logic [15:0] d4 = '0;
   logic        ov4, ordy4 = 1'b1;
   logic [3:0]  od4;
   logic [1:0]  och4;

   logic [2:0]  v3 = '0, r3;
   logic [11:0] d3 = '0;
   logic        ov3, ordy3 = 1'b1;
   logic [3:0]  od3;
   logic [1:0]  och3;

   rr_mux_n #(.N_CH(4), .W(4)) dut (
      .clk(clk), .rst(rst), .in_valid(v4), .in_data(d4), .in_ready(r4),
      .out_valid(ov4), .out_data(od4), .out_ch(och4), .out_ready(ordy4)
   );

   rr_mux_n #(.N_CH(3), .W(4)) dut3 (
      .clk(clk), .rst(rst), .in_valid(v3), .in_data(d3), .in_ready(r3),
      .out_valid(ov3), .out_data(od3), .out_ch(och3), .out_ready(ordy3)
   );

   int checks = 0;
   int failures = 0;

   // Reference model of the 4-channel instance
   bit         m_ov = 1'b0;
   logic [3:0] m_od = '0;
   int         m_och = 0;
   int         m_ptr = 0;

   function automatic int pick(input logic [3:0] v, input int p, input bit cl);
      if (!cl) return -1;
      for (int k = 0; k < 4; k++) begin
         int c = (p + k) % 4;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   function automatic logic [3:0] exp_rdy();
      int g = pick(v4, m_ptr, !m_ov || ordy4);
      if (rst || g < 0) return 4'b0000;
      return 4'(1 << g);
   endfunction

   task automatic tick();
      int g = rst ? -1 : pick(v4, m_ptr, !m_ov || ordy4);
      @(posedge clk);
      if (rst) begin
         m_ov = 1'b0; m_od = '0; m_och = 0; m_ptr = 0;
      end else if (g >= 0) begin
         m_od = d4[g*4 +: 4]; m_och = g; m_ov = 1'b1; m_ptr = (g + 1) % 4;
      end else if (m_ov && ordy4) begin
         m_ov = 1'b0;
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; v4 = 4'b1111; d4 = 16'h1234; ordy4 = 1'b1;
      #1;
      checks++;
      if (r4 !== 4'b0000) begin
         failures++; $display("FAIL reset_in_ready got=%b exp=0000", r4);
      end
      tick(); tick();
      rst = 1'b0; v4 = '0;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (ov4 !== 1'b0 || r4 !== 4'b0000 || od4 !== 4'h0 || och4 !== 2'd0) begin
            failures++;
            $display("FAIL reset_idle got ov=%b rdy=%b data=%h ch=%0d exp ov=0 rdy=0000 data=0 ch=0",
                     ov4, r4, od4, och4);
         end
         tick();
      end
   endtask

   task automatic test_round_robin();
      v4 = 4'b1111; d4 = 16'h4321; ordy4 = 1'b1;
      #1;
      checks++;
      if (r4 !== 4'b0001) begin
         failures++; $display("FAIL rr_first_grant got=%b exp=0001", r4);
      end
      tick();
      for (int j = 0; j < 8; j++) begin
         #1;
         checks++;
         if (ov4 !== 1'b1 || od4 !== 4'(j % 4 + 1) || och4 !== 2'(j % 4)) begin
            failures++;
            $display("FAIL rr_seq[%0d] got ov=%b data=%h ch=%0d exp ov=1 data=%h ch=%0d",
                     j, ov4, od4, och4, 4'(j % 4 + 1), j % 4);
         end
         checks++;
         if (r4 !== exp_rdy()) begin
            failures++; $display("FAIL rr_ready[%0d] got=%b exp=%b", j, r4, exp_rdy());
         end
         tick();
      end
   endtask

   task automatic test_single();
      v4 = 4'b0100; d4 = 16'h0A00; ordy4 = 1'b1;
      for (int j = 0; j < 3; j++) begin
         #1;
         checks++;
         if (r4 !== 4'b0100) begin
            failures++; $display("FAIL single_ready[%0d] got=%b exp=0100", j, r4);
         end
         tick();
         checks++;
         if (ov4 !== 1'b1 || od4 !== 4'hA || och4 !== 2'd2) begin
            failures++;
            $display("FAIL single_out[%0d] got ov=%b data=%h ch=%0d exp ov=1 data=a ch=2",
                     j, ov4, od4, och4);
         end
      end
   endtask

   task automatic test_backpressure();
      rst = 1'b1; v4 = '0; tick(); rst = 1'b0;
      v4 = 4'b1010; d4 = 16'h9050; ordy4 = 1'b0;
      #1;
      checks++;
      if (r4 !== 4'b0010) begin
         failures++; $display("FAIL bp_first_ready got=%b exp=0010", r4);
      end
      tick();
      for (int j = 0; j < 4; j++) begin
         #1;
         checks++;
         if (r4 !== 4'b0000 || ov4 !== 1'b1 || od4 !== 4'h5 || och4 !== 2'd1) begin
            failures++;
            $display("FAIL bp_stall[%0d] got rdy=%b ov=%b data=%h ch=%0d exp rdy=0000 ov=1 data=5 ch=1",
                     j, r4, ov4, od4, och4);
         end
         tick();
      end
      ordy4 = 1'b1;
      #1;
      checks++;
      if (r4 !== 4'b1000) begin
         failures++; $display("FAIL bp_release_ready got=%b exp=1000", r4);
      end
      tick();
      checks++;
      if (ov4 !== 1'b1 || od4 !== 4'h9 || och4 !== 2'd3) begin
         failures++;
         $display("FAIL bp_release_out got ov=%b data=%h ch=%0d exp ov=1 data=9 ch=3", ov4, od4, och4);
      end
   endtask

   task automatic test_wrap3();
      rst = 1'b1; tick(); rst = 1'b0;
      ordy3 = 1'b1; v3 = 3'b100; d3 = 12'h7B0;
      #1;
      checks++;
      if (r3 !== 3'b100) begin
         failures++; $display("FAIL wrap3_ready_ch2 got=%b exp=100", r3);
      end
      tick();
      checks++;
      if (ov3 !== 1'b1 || od3 !== 4'h7 || och3 !== 2'd2) begin
         failures++; $display("FAIL wrap3_out_ch2 got ov=%b data=%h ch=%0d exp ov=1 data=7 ch=2", ov3, od3, och3);
      end
      v3 = 3'b010;
      #1;
      checks++;
      if (r3 !== 3'b010) begin
         failures++; $display("FAIL wrap3_ready_ch1 got=%b exp=010", r3);
      end
      tick();
      checks++;
      if (ov3 !== 1'b1 || od3 !== 4'hB || och3 !== 2'd1) begin
         failures++; $display("FAIL wrap3_out_ch1 got ov=%b data=%h ch=%0d exp ov=1 data=b ch=1", ov3, od3, och3);
      end
      v3 = 3'b111;
      #1;
      checks++;
      if (r3 !== 3'b100) begin
         failures++; $display("FAIL wrap3_ptr2 got=%b exp=100", r3);
      end
      tick();
      v3 = '0;
   endtask

   task automatic test_reset_mid();
      v4 = '0; ordy4 = 1'b1; tick(); tick();
      v4 = 4'b0001; d4 = 16'h000C; ordy4 = 1'b0;
      tick();
      checks++;
      if (ov4 !== 1'b1 || od4 !== 4'hC) begin
         failures++; $display("FAIL rstmid_load got ov=%b data=%h exp ov=1 data=c", ov4, od4);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (r4 !== 4'b0000) begin
         failures++; $display("FAIL rstmid_ready got=%b exp=0000", r4);
      end
      tick();
      checks++;
      if (ov4 !== 1'b0) begin
         failures++; $display("FAIL rstmid_drop got ov=%b exp=0", ov4);
      end
      rst = 1'b0; v4 = 4'b1111; ordy4 = 1'b1;
      #1;
      checks++;
      if (r4 !== 4'b0001) begin
         failures++; $display("FAIL rstmid_prio got=%b exp=0001", r4);
      end
      tick();
      checks++;
      if (och4 !== 2'd0 || ov4 !== 1'b1) begin
         failures++; $display("FAIL rstmid_ch0 got ch=%0d ov=%b exp ch=0 ov=1", och4, ov4);
      end
   endtask

   task automatic test_random();
      logic [3:0] rdy_before;
      for (int n = 0; n < 400; n++) begin
         rst   = ($urandom_range(0, 49) == 0);
         v4    = 4'($urandom);
         d4    = 16'($urandom);
         ordy4 = ($urandom_range(0, 3) != 0);
         #1;
         checks++;
         if (r4 !== exp_rdy()) begin
            failures++; $display("FAIL rand_ready[%0d] got=%b exp=%b", n, r4, exp_rdy());
         end
         checks++;
         if (ov4 !== m_ov || od4 !== m_od || och4 !== 2'(m_och)) begin
            failures++;
            $display("FAIL rand_out[%0d] got ov=%b data=%h ch=%0d exp ov=%b data=%h ch=%0d",
                     n, ov4, od4, och4, m_ov, m_od, m_och);
         end
         rdy_before = exp_rdy();
         d4 = 16'($urandom);
         #1;
         checks++;
         if (r4 !== rdy_before) begin
            failures++; $display("FAIL rand_data_indep[%0d] got=%b exp=%b", n, r4, rdy_before);
         end
         tick();
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_backpressure();
      test_wrap3();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
